// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the N-stage pipeline controller.
// Stage numbering: 0 = IF, 1 = ID, last stage = WB.
package pipeline_ctrl_pkg;

    localparam int STAGE_IF = 0;
    localparam int STAGE_ID = 1;

    // Widest register address any instance may use; narrower addresses are zero-extended.
    localparam int MAX_REG_ADDR_W = 8;

    localparam logic [MAX_REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] rd;
        logic                      wren;
    } stage_info_t;

    // What the controller does with the pipeline registers this cycle.
    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_FREEZE,
        MODE_REDIRECT,
        MODE_STALL,
        MODE_RUN
    } ctrl_mode_t;

    function automatic int STAGE_WB(input int numStages);
        return numStages - 1;
    endfunction

endpackage

// File: rtl/hazard_detector.sv
// Combinational RAW detector: compares the ID sources against every
// in-flight destination in the supplied compare window.
module hazard_detector
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_WIN    = 3,
    parameter int REG_ADDR_W = 5
) (
    input  stage_info_t [NUM_WIN-1:0] i_window,
    input  logic                      i_idValid,
    input  logic [REG_ADDR_W-1:0]     i_rs1Addr,
    input  logic [REG_ADDR_W-1:0]     i_rs2Addr,
    input  logic                      i_rs1Used,
    input  logic                      i_rs2Used,
    output logic                      o_hazard
);

    logic [MAX_REG_ADDR_W-1:0] w_rs1;
    logic [MAX_REG_ADDR_W-1:0] w_rs2;
    logic                      w_rs1Hit;
    logic                      w_rs2Hit;

    // x0 is hardwired, so a source of x0 can never depend on anything in flight.
    always_comb begin
        w_rs1                   = REG_ZERO;
        w_rs2                   = REG_ZERO;
        w_rs1[REG_ADDR_W-1:0]   = i_rs1Addr;
        w_rs2[REG_ADDR_W-1:0]   = i_rs2Addr;
        w_rs1Hit                = 1'b0;
        w_rs2Hit                = 1'b0;
        for (int k = 0; k < NUM_WIN; k++) begin
            if (i_window[k].valid && i_window[k].wren) begin
                if (i_window[k].rd == w_rs1) begin
                    w_rs1Hit = 1'b1;
                end
                if (i_window[k].rd == w_rs2) begin
                    w_rs2Hit = 1'b1;
                end
            end
        end
        o_hazard = i_idValid &&
                   ((i_rs1Used && (w_rs1 != REG_ZERO) && w_rs1Hit) ||
                    (i_rs2Used && (w_rs2 != REG_ZERO) && w_rs2Hit));
    end

endmodule

// File: rtl/pipeline_controller.sv
// Control block for an N-stage in-order pipeline: valid tracking, RAW stalls,
// redirect flushes and WB commit. Optional macro PIPELINE_CONTROLLER_WB_BYPASS_EN.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int REDIRECT_STAGE = 3,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ext_stall,
    input  logic                  redirect,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_wren,
    output logic                  pc_wren,
    output logic                  pc_redirect_sel,
    output logic [NUM_STAGES-2:0] pipe_wren,
    output logic [NUM_STAGES-2:0] pipe_bubble,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  hazard_stall,
    output logic                  reg_commit,
    output logic [31:0]           retire_count
);

    localparam int WB      = STAGE_WB(NUM_STAGES);
    localparam int WIN_LO  = STAGE_ID + 1;
`ifdef PIPELINE_CONTROLLER_WB_BYPASS_EN
    // Write-through register file: a producer in WB is already visible to ID.
    localparam int WIN_HI  = NUM_STAGES - 2;
`else
    localparam int WIN_HI  = NUM_STAGES - 1;
`endif
    localparam int NUM_WIN = WIN_HI - WIN_LO + 1;

    logic                                r_validIf;
    logic                                r_validId;
    stage_info_t [NUM_STAGES-1:WIN_LO]   r_stage;
    logic [31:0]                         r_retireCount;

    stage_info_t [NUM_WIN-1:0]           w_window;
    stage_info_t                         w_idInfo;
    logic                                w_rawHazard;
    ctrl_mode_t                          w_mode;

    assign w_window = r_stage[WIN_HI:WIN_LO];

    hazard_detector #(
        .NUM_WIN    (NUM_WIN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazardDetector (
        .i_window  (w_window),
        .i_idValid (r_validId),
        .i_rs1Addr (id_rs1_addr),
        .i_rs2Addr (id_rs2_addr),
        .i_rs1Used (id_rs1_used),
        .i_rs2Used (id_rs2_used),
        .o_hazard  (w_rawHazard)
    );

    always_comb begin
        w_idInfo                    = '0;
        w_idInfo.valid              = r_validId;
        w_idInfo.rd[REG_ADDR_W-1:0] = id_rd_addr;
        w_idInfo.wren               = id_reg_wren;
    end

    // Priority: reset, external freeze, redirect, RAW stall, normal flow.
    always_comb begin
        w_mode = MODE_RUN;
        if (!reset_n) begin
            w_mode = MODE_RESET;
        end else if (ext_stall) begin
            w_mode = MODE_FREEZE;
        end else if (redirect) begin
            w_mode = MODE_REDIRECT;
        end else if (w_rawHazard) begin
            w_mode = MODE_STALL;
        end
    end

    always_comb begin
        pc_wren         = 1'b0;
        pc_redirect_sel = 1'b0;
        pipe_wren       = '0;
        pipe_bubble     = '0;
        hazard_stall    = 1'b0;
        case (w_mode)
            MODE_REDIRECT: begin
                pc_wren         = 1'b1;
                pc_redirect_sel = 1'b1;
                pipe_wren       = '1;
                for (int i = 0; i < REDIRECT_STAGE; i++) begin
                    pipe_bubble[i] = 1'b1;
                end
            end
            MODE_STALL: begin
                hazard_stall   = 1'b1;
                pipe_wren      = '1;
                pipe_wren[0]   = 1'b0;
                pipe_bubble[1] = 1'b1;
            end
            MODE_RUN: begin
                pc_wren   = 1'b1;
                pipe_wren = '1;
            end
            default: begin
            end
        endcase
    end

    assign reg_commit = reset_n & ~ext_stall & r_stage[WB].valid & r_stage[WB].wren;

    always_comb begin
        stage_valid           = '0;
        stage_valid[STAGE_IF] = r_validIf;
        stage_valid[STAGE_ID] = r_validId;
        for (int k = WIN_LO; k < NUM_STAGES; k++) begin
            stage_valid[k] = r_stage[k].valid;
        end
    end

    // IF becomes valid once the PC has been loaded sequentially; a redirect
    // load leaves it invalid for that cycle, matching the flush of stages below.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_validIf     <= 1'b0;
            r_validId     <= 1'b0;
            r_stage       <= '0;
            r_retireCount <= '0;
        end else begin
            if (pc_wren) begin
                r_validIf <= ~pc_redirect_sel;
            end
            if (pipe_wren[0]) begin
                r_validId <= r_validIf & ~pipe_bubble[0];
            end
            if (pipe_wren[1]) begin
                r_stage[WIN_LO] <= pipe_bubble[1] ? '0 : w_idInfo;
            end
            for (int i = WIN_LO; i < NUM_STAGES - 1; i++) begin
                if (pipe_wren[i]) begin
                    r_stage[i+1] <= pipe_bubble[i] ? '0 : r_stage[i];
                end
            end
            if (r_stage[WB].valid && !ext_stall) begin
                r_retireCount <= r_retireCount + 32'd1;
            end
        end
    end

    assign retire_count = r_retireCount;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller (5 stages, redirect in stage 3).
// Expected values are hand-derived; the WB-bypass build changes the RAW stall length.
module tb_pipeline_controller;

    localparam int NS = 5;
    localparam int RS = 3;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ext_stall;
    logic          redirect;
    logic [AW-1:0] id_rs1_addr;
    logic [AW-1:0] id_rs2_addr;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [AW-1:0] id_rd_addr;
    logic          id_reg_wren;
    logic          pc_wren;
    logic          pc_redirect_sel;
    logic [NS-2:0] pipe_wren;
    logic [NS-2:0] pipe_bubble;
    logic [NS-1:0] stage_valid;
    logic          hazard_stall;
    logic          reg_commit;
    logic [31:0]   retire_count;

    int checkCount = 0;
    int errorCount = 0;

    pipeline_controller #(
        .NUM_STAGES     (NS),
        .REDIRECT_STAGE (RS),
        .REG_ADDR_W     (AW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ext_stall       (ext_stall),
        .redirect        (redirect),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd_addr      (id_rd_addr),
        .id_reg_wren     (id_reg_wren),
        .pc_wren         (pc_wren),
        .pc_redirect_sel (pc_redirect_sel),
        .pipe_wren       (pipe_wren),
        .pipe_bubble     (pipe_bubble),
        .stage_valid     (stage_valid),
        .hazard_stall    (hazard_stall),
        .reg_commit      (reg_commit),
        .retire_count    (retire_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ext, input logic redir,
                                 input logic [AW-1:0] rs1, input logic rs1Used,
                                 input logic [AW-1:0] rs2, input logic rs2Used,
                                 input logic [AW-1:0] rd, input logic wren);
        ext_stall   = ext;
        redirect    = redir;
        id_rs1_addr = rs1;
        id_rs1_used = rs1Used;
        id_rs2_addr = rs2;
        id_rs2_used = rs2Used;
        id_rd_addr  = rd;
        id_reg_wren = wren;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        applyStimulus(0, 0, 10, 1, 10, 1, 1, 1);
        stepCycle();
        stepCycle();
        checkOutput("rst_valid", stage_valid, 5'h00);
        checkOutput("rst_retire", retire_count, 32'd0);
        checkOutput("rst_pc_wren", pc_wren, 1'b0);
        checkOutput("rst_pipe_wren", pipe_wren, 4'h0);
        checkOutput("rst_bubble", pipe_bubble, 4'h0);
        checkOutput("rst_commit", reg_commit, 1'b0);
        checkOutput("rst_hazard", hazard_stall, 1'b0);

        // Straight-line independent stream
        reset_n = 1'b1;
        #1;
        checkOutput("first_pc_wren", pc_wren, 1'b1);
        checkOutput("first_valid", stage_valid, 5'h00);
        checkOutput("first_pipe_wren", pipe_wren, 4'hF);
        checkOutput("first_sel", pc_redirect_sel, 1'b0);
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            checkOutput("fill_hazard", hazard_stall, 1'b0);
        end
        checkOutput("fill_valid", stage_valid, 5'h1F);
        checkOutput("fill_commit", reg_commit, 1'b1);
        checkOutput("fill_retire", retire_count, 32'd0);
        repeat (10) stepCycle();
        checkOutput("stream_retire", retire_count, 32'd10);

        // Redirect coincident with a RAW hazard, held through a 4-cycle freeze
        applyStimulus(0, 0, 10, 1, 10, 1, 9, 1);
        stepCycle();
        applyStimulus(1, 1, 9, 1, 0, 0, 1, 1);
        checkOutput("frz_pc_wren", pc_wren, 1'b0);
        checkOutput("frz_pipe_wren", pipe_wren, 4'h0);
        checkOutput("frz_commit", reg_commit, 1'b0);
        checkOutput("frz_hazard", hazard_stall, 1'b0);
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput("frz_hold_valid", stage_valid, 5'h1F);
            checkOutput("frz_hold_retire", retire_count, 32'd11);
            checkOutput("frz_hold_commit", reg_commit, 1'b0);
        end
        applyStimulus(0, 1, 9, 1, 0, 0, 1, 1);
        checkOutput("redir_hazard", hazard_stall, 1'b0);
        checkOutput("redir_sel", pc_redirect_sel, 1'b1);
        checkOutput("redir_pc_wren", pc_wren, 1'b1);
        checkOutput("redir_pipe_wren", pipe_wren, 4'hF);
        checkOutput("redir_bubble", pipe_bubble, 4'h7);
        checkOutput("redir_commit", reg_commit, 1'b1);
        stepCycle();
        applyStimulus(0, 0, 10, 1, 10, 1, 1, 1);
        checkOutput("post_redir_valid", stage_valid, 5'h10);
        checkOutput("post_redir_sel", pc_redirect_sel, 1'b0);
        checkOutput("post_redir_retire", retire_count, 32'd12);

        // Single-cycle reset mid-stream
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_pc_wren", pc_wren, 1'b0);
        checkOutput("mid_rst_commit", reg_commit, 1'b0);
        checkOutput("mid_rst_pipe_wren", pipe_wren, 4'h0);
        stepCycle();
        reset_n = 1'b1;
        #1;
        checkOutput("mid_rst_valid", stage_valid, 5'h00);
        checkOutput("mid_rst_retire", retire_count, 32'd0);
        checkOutput("mid_rst_pc_wren_after", pc_wren, 1'b1);

        // RAW: addi x5,x0 followed by add x6,x0,x5
        repeat (5) stepCycle();
        checkOutput("refill_valid", stage_valid, 5'h1F);
        applyStimulus(0, 0, 0, 1, 0, 0, 5, 1);
        checkOutput("raw_producer_hazard", hazard_stall, 1'b0);
        stepCycle();
        applyStimulus(0, 0, 0, 1, 5, 1, 6, 1);
        checkOutput("raw_t1_hazard", hazard_stall, 1'b1);
        checkOutput("raw_t1_pc_wren", pc_wren, 1'b0);
        checkOutput("raw_t1_pipe_wren", pipe_wren, 4'hE);
        checkOutput("raw_t1_bubble", pipe_bubble, 4'h2);
        stepCycle();
        checkOutput("raw_t2_valid", stage_valid, 5'h1B);
        checkOutput("raw_t2_hazard", hazard_stall, 1'b1);
        stepCycle();
        checkOutput("raw_t3_commit", reg_commit, 1'b1);
        checkOutput("raw_t3_valid", stage_valid, 5'h13);
`ifdef PIPELINE_CONTROLLER_WB_BYPASS_EN
        checkOutput("raw_t3_hazard", hazard_stall, 1'b0);
`else
        checkOutput("raw_t3_hazard", hazard_stall, 1'b1);
        stepCycle();
        checkOutput("raw_t4_hazard", hazard_stall, 1'b0);
`endif
        checkOutput("raw_release_pc_wren", pc_wren, 1'b1);
        checkOutput("raw_release_pipe_wren", pipe_wren, 4'hF);

        // x0 sources against an in-flight rd=0 producer
        stepCycle();
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 1);
        checkOutput("x0_hazard_a", hazard_stall, 1'b0);
        stepCycle();
        checkOutput("x0_hazard_b", hazard_stall, 1'b0);

        // Unused source never hazards; the same source used does
        applyStimulus(0, 0, 0, 0, 0, 0, 12, 1);
        stepCycle();
        applyStimulus(0, 0, 12, 0, 0, 0, 1, 1);
        checkOutput("unused_rs1_hazard", hazard_stall, 1'b0);
        applyStimulus(0, 0, 12, 1, 0, 0, 1, 1);
        checkOutput("used_rs1_hazard", hazard_stall, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
